accumulator_8_bits: RTL and testbench

ACCUMULATOR_8_BITS -- requirements
Module: accumulator_8_bits

---
 rtl/accumulator_8_bits.sv | 108 ++++++++++
 tb/tb_accumulator_8_bits.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/accumulator_8_bits.sv
// accumulator_8_bits
//   Sums N_SAMPLES operands from an upstream adder stage, then holds the
//   result until downstream consumes it. Two-state handshake FSM:
//   ACCUM accepts operands, HOLD presents the completed run.
//
// Ports
//   clk_i        sole clock, rising edge
//   reset_n_i    synchronous active-low reset
//   clear_i      synchronous abort of the current run / held result
//   data_in_i    operand (upstream adder SUM bus)
//   in_valid_i   operand valid
//   in_ready_o   block accepts an operand this cycle (ACCUM)
//   result_o     registered accumulator, modulo 2^WIDTH
//   ovf_o        sticky carry-out of any accumulation step in this run
//   out_valid_o  result_o/ovf_o hold a completed run (HOLD)
//   out_ready_i  downstream consumes the result this cycle
//   count_o      operands accepted in the current run
module accumulator_8_bits #(
  parameter int WIDTH     = 8,
  parameter int N_SAMPLES = 4   // legal range 2..15 (count_o is 4 bits)
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] data_in_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] result_o,
  output logic             ovf_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [3:0]       count_o
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_e;

  localparam logic [3:0] LAST = 4'(N_SAMPLES - 1);

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic             ovf_q;
  logic [3:0]       cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;

  // Next values for an accepted operand. Carry-in is always 0; the carry-out
  // of this single addition feeds the sticky overflow flag.
  logic [WIDTH-1:0] acc_d;
  logic             carry_d;
  logic             ovf_d;
  logic [3:0]       cnt_d;

  assign {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, data_in_i};
  assign ovf_d            = ovf_q | carry_d;
  assign cnt_d            = cnt_q + 4'd1;

  // Single-process FSM. Handshake flags are registered alongside the state so
  // they never depend combinationally on in_valid_i / out_ready_i.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i || clear_i) begin
      // reset and clear share the same effect; reset simply wins priority
      state_q     <= ACCUM;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= 4'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid_i) begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
            if (cnt_q == LAST) begin
              state_q     <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          // operand inputs are ignored here; only the consume ends the run
          if (out_ready_i) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= 4'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ACCUM;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign result_o    = acc_q;
  assign ovf_o       = ovf_q;
  assign count_o     = cnt_q;

endmodule

// File: tb/tb_accumulator_8_bits.sv
// Bench for accumulator_8_bits: directed scenarios plus randomized traffic.
// A reference model tracks the list of accepted operands; expected results
// are derived from their plain integer sum. A scoreboard queue holds the
// expected completed run, popped by a monitor on each output handshake.
module tb_accumulator_8_bits;
  localparam int NS = 4;

  logic       clk = 1'b0;
  logic       reset_n, clear, in_valid, out_ready;
  logic [7:0] data_in;
  logic       in_ready, ovf, out_valid;
  logic [7:0] result;
  logic [3:0] count;

  int total = 0;
  int bad   = 0;

  accumulator_8_bits #(.WIDTH(8), .N_SAMPLES(NS)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .clear_i(clear),
    .data_in_i(data_in), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .result_o(result), .ovf_o(ovf), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .count_o(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  ops[$];     // operands accepted in the current run
  logic [12:0] exp_q[$];   // {count, ovf, result} of completed runs
  bit m_hold = 0;
  bit armed  = 0;

  function automatic int unsigned opsum();
    int unsigned s = 0;
    foreach (ops[i]) s += ops[i];
    return s;
  endfunction

  initial forever begin
    int unsigned s;
    @(posedge clk);
    if (!reset_n || clear) begin
      if (!reset_n) armed = 1;
      if (m_hold && exp_q.size() > 0) void'(exp_q.pop_back());
      ops.delete();
      m_hold = 0;
    end else if (!m_hold) begin
      if (in_valid) begin
        ops.push_back(data_in);
        if (ops.size() == NS) begin
          s = opsum();
          exp_q.push_back({4'(NS), (s > 255), 8'(s)});
          m_hold = 1;
        end
      end
    end else if (out_ready) begin
      m_hold = 0;
      ops.delete();
    end
  end

  // ---------------- monitor ----------------
  initial forever begin
    int unsigned s;
    logic [12:0] e;
    @(negedge clk);
    if (armed) begin
      s = opsum();
      chk("in_ready",  32'(in_ready),  32'(!m_hold));
      chk("out_valid", 32'(out_valid), 32'(m_hold));
      chk("result",    32'(result),    32'(s % 256));
      chk("ovf",       32'(ovf),       32'(s > 255));
      chk("count",     32'(count),     32'(ops.size()));
      if (out_valid && out_ready && reset_n && !clear) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_unexpected actual=out_valid required=no_result t=%0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("sb_result", 32'(result), 32'(e[7:0]));
          chk("sb_ovf",    32'(ovf),    32'(e[8]));
          chk("sb_count",  32'(count),  32'(e[12:9]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic v, input logic [7:0] d, input logic ordy, input logic clr);
    in_valid = v; data_in = d; out_ready = ordy; clear = clr;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] a[4];
    reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; data_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    reset_n = 1'b1;

    // sum of 1..4, immediate consume
    a = '{8'h01, 8'h02, 8'h03, 8'h04};
    foreach (a[i]) cyc(1'b1, a[i], 1'b1, 1'b0);
    chk("d1_out_valid", 32'(out_valid), 32'h1);
    chk("d1_result", 32'(result), 32'h0A);
    chk("d1_ovf", 32'(ovf), 32'h0);
    chk("d1_count", 32'(count), 32'h4);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("d1_one_cycle", 32'(out_valid), 32'h0);

    // wrap to zero with overflow, then a clean run
    a = '{8'hFF, 8'h01, 8'h00, 8'h00};
    foreach (a[i]) cyc(1'b1, a[i], 1'b1, 1'b0);
    chk("d2_result", 32'(result), 32'h00);
    chk("d2_ovf", 32'(ovf), 32'h1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (4) cyc(1'b1, 8'h10, 1'b1, 1'b0);
    chk("d2b_result", 32'(result), 32'h40);
    chk("d2b_ovf", 32'(ovf), 32'h0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // held result stays put with back-pressure; operand pulses ignored
    a = '{8'h80, 8'h80, 8'h01, 8'h01};
    foreach (a[i]) cyc(1'b1, a[i], 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("d3_result", 32'(result), 32'h02);
      chk("d3_ovf", 32'(ovf), 32'h1);
      chk("d3_in_ready", 32'(in_ready), 32'h0);
      if (k < 3) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
      else       cyc(1'b1, 8'h55, 1'b1, 1'b0);
    end
    chk("d3_released", 32'(out_valid), 32'h0);
    chk("d3_cnt0", 32'(count), 32'h0);

    // toggling valid
    for (int k = 0; k < 8; k++) begin
      cyc(k[0] == 1'b0, 8'h05, 1'b0, 1'b0);
      chk("d4_count", 32'(count), 32'((k / 2) + 1));
    end
    chk("d4_result", 32'(result), 32'h14);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // clear mid-run drops the concurrent operand
    cyc(1'b1, 8'h11, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 1'b0, 1'b0);
    chk("d5_partial", 32'(result), 32'h33);
    cyc(1'b1, 8'h33, 1'b0, 1'b1);
    chk("d5_result", 32'(result), 32'h00);
    chk("d5_count", 32'(count), 32'h0);

    // reset while holding
    a = '{8'h01, 8'h02, 8'h03, 8'h04};
    foreach (a[i]) cyc(1'b1, a[i], 1'b0, 1'b0);
    chk("d6_hold", 32'(result), 32'h0A);
    reset_n = 1'b0;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    reset_n = 1'b1;
    chk("d6_out_valid", 32'(out_valid), 32'h0);
    chk("d6_result", 32'(result), 32'h00);
    chk("d6_in_ready", 32'(in_ready), 32'h1);

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      reset_n = ($urandom_range(99) != 0);
      cyc($urandom_range(3) != 0, 8'($urandom), $urandom_range(9) < 7,
          $urandom_range(29) == 0);
    end
    reset_n = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
